// File: rtl/irq_priority_ctrl.sv
// 32-source interrupt controller: request capture into a pending register, software mask,
// priority offer through a valid/ack handshake, and non-nested service until end-of-interrupt.
module irq_priority_ctrl #(
  parameter int EDGE_MODE = 1,
  parameter int NUM_SRC   = 32,
  parameter int ID_W      = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] req,
  input  logic               mask_wr,
  input  logic [NUM_SRC-1:0] mask_wdata,
  output logic [NUM_SRC-1:0] mask,
  output logic [NUM_SRC-1:0] pending,
  output logic               irq_valid,
  output logic [ID_W-1:0]    irq_id,
  input  logic               irq_ack,
  input  logic               eoi,
  output logic               busy,
  output logic [ID_W-1:0]    in_service_id
);

  typedef enum logic [1:0] {IDLE, OFFER, SERVICE} state_t;

  state_t             state_reg, state_next;
  logic [NUM_SRC-1:0] req_q_reg, pending_reg, pending_next, mask_reg;
  logic [NUM_SRC-1:0] set_vec, clr_vec, elig;
  logic               irq_valid_reg, irq_valid_next, busy_reg, busy_next;
  logic [ID_W-1:0]    irq_id_reg, irq_id_next, in_service_id_reg, in_service_id_next;
  logic [ID_W-1:0]    winner;
  logic               ack_take;

  generate
    if (EDGE_MODE != 0) begin : g_edge
      assign set_vec = req & ~req_q_reg;
    end else begin : g_level
      assign set_vec = req;
    end
  endgenerate

  // The ack always refers to the registered irq_id currently presented.
  assign ack_take = (state_reg == OFFER) && irq_ack;

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_clr
      assign clr_vec[gi] = ack_take && (irq_id_reg == ID_W'(gi));
    end
  endgenerate

  // Set is OR-ed after the clear so a coincident new event survives the ack.
  assign pending_next = (pending_reg & ~clr_vec) | set_vec;
  assign elig         = pending_reg & ~mask_reg;

  always_comb begin
    winner = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (elig[i]) winner = ID_W'(i);
    end
  end

  always_comb begin
    state_next         = state_reg;
    irq_valid_next     = irq_valid_reg;
    irq_id_next        = irq_id_reg;
    busy_next          = busy_reg;
    in_service_id_next = in_service_id_reg;
    case (state_reg)
      IDLE: begin
        if (elig != '0) begin
          state_next     = OFFER;
          irq_valid_next = 1'b1;
          irq_id_next    = winner;
        end
      end
      OFFER: begin
        if (irq_ack) begin
          state_next         = SERVICE;
          irq_valid_next     = 1'b0;
          busy_next          = 1'b1;
          in_service_id_next = irq_id_reg;
        end else if (elig == '0) begin
          state_next     = IDLE;
          irq_valid_next = 1'b0;
        end else begin
          irq_id_next = winner;
        end
      end
      SERVICE: begin
        if (eoi) begin
          state_next = IDLE;
          busy_next  = 1'b0;
        end
      end
      default: begin
        state_next     = IDLE;
        irq_valid_next = 1'b0;
        busy_next      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= IDLE;
      req_q_reg         <= '0;
      pending_reg       <= '0;
      mask_reg          <= '1;
      irq_valid_reg     <= 1'b0;
      irq_id_reg        <= '0;
      busy_reg          <= 1'b0;
      in_service_id_reg <= '0;
    end else begin
      state_reg         <= state_next;
      req_q_reg         <= req;
      pending_reg       <= pending_next;
      if (mask_wr) mask_reg <= mask_wdata;
      irq_valid_reg     <= irq_valid_next;
      irq_id_reg        <= irq_id_next;
      busy_reg          <= busy_next;
      in_service_id_reg <= in_service_id_next;
    end
  end

  assign mask          = mask_reg;
  assign pending       = pending_reg;
  assign irq_valid     = irq_valid_reg;
  assign irq_id        = irq_id_reg;
  assign busy          = busy_reg;
  assign in_service_id = in_service_id_reg;

endmodule
